// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the square-wave tone oscillator:
//   DEF_DIV_W   default width of the period divider and internal counter
//   DEF_AMP_W   default width of amplitude input / sample output
//   MIN_DIV     smallest divider that produces a waveform
//   osc_state_t oscillator control state
// ---------------------------------------------------------------------------
package tone_pkg;

  localparam int DEF_DIV_W = 19;
  localparam int DEF_AMP_W = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } osc_state_t;

endpackage

// File: rtl/tone_osc_phase_counter.sv
// ---------------------------------------------------------------------------
// phase_counter
// Counts clock cycles within one half of the square wave and flags the last
// cycle of that half. The counter wraps to zero on its own terminal count so
// the next half starts cleanly without help from the controller.
// Ports:
//   clk       system clock
//   n_rst     synchronous active-low reset
//   clear     hold count at zero (oscillator idle)
//   half_len  length of the current half phase in clk cycles
//   count     current position within the half phase
//   tc        high on the last cycle of the half phase
// ---------------------------------------------------------------------------
module phase_counter
  import tone_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] half_len,
  output logic [DIV_W-1:0] count,
  output logic             tc
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_last;

  assign w_last = half_len - ONE;
  assign tc     = (r_count == w_last);
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (!n_rst || clear || tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + ONE;
    end
  end

endmodule

// File: rtl/tone_osc.sv
// ---------------------------------------------------------------------------
// tone_osc
// 50%-duty square-wave tone generator. A full period lasts `divider` clock
// cycles: the high half is divider>>1 cycles, the low half takes the rest, so
// an odd divider gives a low half one cycle longer. The divider is latched
// only when a period completes (low-to-high edge), keeping pitch changes
// glitch-free. Dropping `en` lets the current period finish (DRAIN) before
// going idle.
// Ports:
//   clk          system clock
//   n_rst        synchronous active-low reset
//   en           note gate, 1 = play
//   divider      full-period length in clk cycles (valid when >= 2)
//   amplitude    output level while the wave is high
//   wave_out     square wave
//   sample       registered wave_out ? amplitude : 0
//   period_tick  one-cycle pulse after each completed period
//   active       high while running or draining
// ---------------------------------------------------------------------------
module tone_osc
  import tone_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int AMP_W = DEF_AMP_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic [DIV_W-1:0] divider,
  input  logic [AMP_W-1:0] amplitude,
  output logic             wave_out,
  output logic [AMP_W-1:0] sample,
  output logic             period_tick,
  output logic             active
);

  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

  osc_state_t       r_state;
  logic [DIV_W-1:0] r_active_div;
  logic             r_phase;      // 1 = high half; drives wave_out directly
  logic [AMP_W-1:0] r_sample;
  logic             r_tick;
  logic             r_active;

  logic [DIV_W-1:0] w_hi_len;
  logic [DIV_W-1:0] w_lo_len;
  logic [DIV_W-1:0] w_half_len;
  logic [DIV_W-1:0] w_count;
  logic             w_tc;
  logic             w_div_ok;
  logic             w_idle;
  osc_state_t       w_gate_state;

  assign w_hi_len     = r_active_div >> 1;
  assign w_lo_len     = r_active_div - w_hi_len;
  assign w_half_len   = r_phase ? w_hi_len : w_lo_len;
  assign w_div_ok     = (divider >= MIN_DIV_V);
  assign w_idle       = (r_state == IDLE);
  assign w_gate_state = en ? RUN : DRAIN;

  phase_counter #(
    .DIV_W(DIV_W)
  ) u_phase_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (w_idle),
    .half_len(w_half_len),
    .count   (w_count),
    .tc      (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_active_div <= '0;
      r_phase      <= 1'b0;
      r_sample     <= '0;
      r_tick       <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en && w_div_ok) begin
            // Start: wave goes high on this edge, first period has no tick.
            r_active_div <= divider;
            r_phase      <= 1'b1;
            r_sample     <= amplitude;
            r_active     <= 1'b1;
            r_state      <= RUN;
          end else begin
            r_phase  <= 1'b0;
            r_sample <= '0;
            r_active <= 1'b0;
          end
        end

        RUN, DRAIN: begin
          if (w_tc && r_phase) begin
            // High-to-low: mid-period, gate only changes the state.
            r_phase  <= 1'b0;
            r_sample <= '0;
            r_state  <= w_gate_state;
          end else if (w_tc) begin
            // Low-to-high: a period has just completed.
            if (r_state == DRAIN && !en) begin
              r_phase  <= 1'b0;
              r_sample <= '0;
              r_active <= 1'b0;
              r_tick   <= 1'b1;
              r_state  <= IDLE;
            end else if (!w_div_ok) begin
              // Bad divider from the lookup: stop silently, no tick.
              r_phase  <= 1'b0;
              r_sample <= '0;
              r_active <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_active_div <= divider;
              r_phase      <= 1'b1;
              r_sample     <= amplitude;
              r_tick       <= 1'b1;
              r_state      <= w_gate_state;
            end
          end else begin
            r_sample <= r_phase ? amplitude : '0;
            r_state  <= w_gate_state;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_phase  <= 1'b0;
          r_sample <= '0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  // The half-phase counter must always stay inside the current half.
  always_ff @(posedge clk) begin
    if (n_rst && !w_idle) begin
      assert (w_count < w_half_len);
    end
  end

  assign wave_out    = r_phase;
  assign sample      = r_sample;
  assign period_tick = r_tick;
  assign active      = r_active;

endmodule

// File: tb/tb_tone_osc.sv
// ---------------------------------------------------------------------------
// tb_tone_osc
// Drives directed and random stimulus into tone_osc. A reference model that
// tracks position within the full period pushes the expected outputs for
// every clock edge into a queue; a monitor on the falling edge pops and
// compares against the DUT.
// ---------------------------------------------------------------------------
module tb_tone_osc;

  localparam int DW = 19;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          en;
  logic [DW-1:0] divider;
  logic [AW-1:0] amplitude;
  logic          wave_out;
  logic [AW-1:0] sample;
  logic          period_tick;
  logic          active;

  tone_osc #(
    .DIV_W(DW),
    .AMP_W(AW)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .en         (en),
    .divider    (divider),
    .amplitude  (amplitude),
    .wave_out   (wave_out),
    .sample     (sample),
    .period_tick(period_tick),
    .active     (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wave;
    logic          tick;
    logic          act;
    logic [AW-1:0] smp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_edge = 0;

  // Reference model: on/off, draining flag, position within full period.
  bit m_on    = 1'b0;
  bit m_drain = 1'b0;
  int m_pos   = 0;
  int m_per   = 0;

  task automatic model(input bit r, input bit e, input int d, input int a);
    exp_t x;
    bit   tk;
    tk = 1'b0;
    if (!r) begin
      m_on = 1'b0; m_drain = 1'b0; m_pos = 0; m_per = 0;
    end else if (!m_on) begin
      if (e && d >= 2) begin
        m_on = 1'b1; m_drain = 1'b0; m_per = d; m_pos = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == m_per) begin
        m_pos = 0;
        if (m_drain && !e) begin
          m_on = 1'b0; tk = 1'b1;
        end else if (d < 2) begin
          m_on = 1'b0;
        end else begin
          m_per = d; tk = 1'b1; m_drain = !e;
        end
      end else begin
        m_drain = !e;
      end
    end
    x.wave = m_on && (m_pos < m_per / 2);
    x.tick = tk;
    x.act  = m_on;
    x.smp  = x.wave ? AW'(a) : '0;
    q.push_back(x);
  endtask

  task automatic step(input bit r, input bit e, input int d, input int a);
    n_rst     = r;
    en        = e;
    divider   = DW'(d);
    amplitude = AW'(a);
    @(posedge clk);
    model(r, e, d, a);
    #1;
  endtask

  task automatic run(input int n, input bit r, input bit e, input int d, input int a);
    for (int i = 0; i < n; i++) step(r, e, d, a);
  endtask

  always @(negedge clk) begin
    exp_t x;
    exp_t got;
    n_edge++;
    if (q.size() > 0) begin
      x   = q.pop_front();
      got = {wave_out, period_tick, active, sample};
      n_cmp++;
      if (got !== x) begin
        n_bad++;
        $display("FAIL outputs@%0d: got wave=%b tick=%b act=%b smp=%h, want wave=%b tick=%b act=%b smp=%h",
                 n_edge, got.wave, got.tick, got.act, got.smp, x.wave, x.tick, x.act, x.smp);
      end
    end
  end

  initial begin
    int cur_d;
    // Reset held with gate on, then release.
    run(3, 1'b0, 1'b1, 10, 8'h80);
    // Even period.
    run(40, 1'b1, 1'b1, 10, 8'h80);
    // Odd period, then minimum period.
    run(33, 1'b1, 1'b1, 11, 8'h80);
    run(12, 1'b1, 1'b1, 2, 8'h5A);
    // Mid-period divider change 10 -> 20.
    run(1, 1'b0, 1'b1, 10, 8'h80);
    run(13, 1'b1, 1'b1, 10, 8'h80);
    run(30, 1'b1, 1'b1, 20, 8'h80);
    // Gate drain to idle.
    run(1, 1'b0, 1'b1, 10, 8'h33);
    run(13, 1'b1, 1'b1, 10, 8'h33);
    run(15, 1'b1, 1'b0, 10, 8'h33);
    // Gate re-asserted during drain.
    run(13, 1'b1, 1'b1, 10, 8'hC4);
    run(4, 1'b1, 1'b0, 10, 8'hC4);
    run(20, 1'b1, 1'b1, 10, 8'hC4);
    // Invalid divider at a boundary.
    run(1, 1'b0, 1'b1, 10, 8'h80);
    run(15, 1'b1, 1'b1, 10, 8'h80);
    run(12, 1'b1, 1'b1, 0, 8'h80);
    run(3, 1'b1, 1'b1, 1, 8'h80);
    // Reset in the middle of a high phase.
    run(13, 1'b1, 1'b1, 10, 8'hFF);
    run(1, 1'b0, 1'b1, 10, 8'hFF);
    run(4, 1'b1, 1'b0, 10, 8'hFF);
    // Random mix.
    cur_d = 10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cur_d = $urandom_range(0, 25);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
           cur_d, $urandom_range(0, 255));
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
